pic_host_master: RTL

CPU-side bus master for the programmable interrupt controller: the initiator end of its host interface. It issues ICW/OCW register writes and optional register reads over CS/WR/RD/A0/DATABUS. When INT is raised it runs the two-pulse INTA acknowledge sequence and captures the vector the controller places on DATABUS. It sits between a simple valid/ready command port (test harness or soft CPU) and the controller's pins.

---
 rtl/pic_host_master.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/pic_host_master.sv
// rtl/pic_host_master.sv - CPU-side host bus master for the interrupt controller; optional readback via PIC_HOST_READBACK_EN
module pic_host_master #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INT,
    output logic       INTA,
    output logic       CS,
    output logic       WR,
    output logic       RD,
    output logic       A0,
    inout  wire  [7:0] DATABUS,
    input  logic       ack_en,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_SETUP,
        ST_W_PULSE,
        ST_W_HOLD,
        ST_R_PULSE,
        ST_ACK1,
        ST_ACK_GAP,
        ST_ACK2,
        ST_RECOVER
    } state_t;

    // Counter reload values: every timed state loads N-1 and leaves when it reaches zero.
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       ext;
    logic       int_meta;
    logic       int_sync;
    logic       ready_en;
    logic       data_oe;
    logic [7:0] data_q;

    // The data bus is only driven while a write transaction owns it.
    assign DATABUS = data_oe ? data_q : 8'bzzzz_zzzz;

    assign busy      = (state != ST_IDLE);
    assign cmd_ready = ready_en && (state == ST_IDLE) && !(int_sync && ack_en);

    // Two-flop synchroniser for the asynchronous interrupt request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_meta <= 1'b0;
            int_sync <= 1'b0;
        end else begin
            int_meta <= INT;
            int_sync <= int_meta;
        end
    end

    // Holds cmd_ready low for the first cycle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

`ifndef PIC_HOST_READBACK_EN
    assign rd_data  = 8'h00;
    assign rd_valid = 1'b0;
`endif

    // Transaction sequencer; all strobes, A0 and data-enable are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= 8'd0;
            ext          <= 1'b0;
            INTA         <= 1'b1;
            CS           <= 1'b1;
            WR           <= 1'b1;
            RD           <= 1'b1;
            A0           <= 1'b0;
            data_oe      <= 1'b0;
            data_q       <= 8'h00;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
`ifdef PIC_HOST_READBACK_EN
            rd_data      <= 8'h00;
            rd_valid     <= 1'b0;
`endif
        end else begin
            vector_valid <= 1'b0;
`ifdef PIC_HOST_READBACK_EN
            rd_valid     <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (int_sync && ack_en) begin
                        state <= ST_ACK1;
                        cnt   <= PULSE_LOAD;
                        INTA  <= 1'b0;
                    end else if (ready_en && cmd_valid) begin
                        if (!cmd_rd) begin
                            state   <= ST_W_SETUP;
                            cnt     <= 8'd0;
                            CS      <= 1'b0;
                            A0      <= cmd_a0;
                            data_q  <= cmd_data;
                            data_oe <= 1'b1;
                        end
`ifdef PIC_HOST_READBACK_EN
                        else begin
                            state <= ST_R_PULSE;
                            cnt   <= PULSE_LOAD;
                            CS    <= 1'b0;
                            RD    <= 1'b0;
                            A0    <= cmd_a0;
                        end
`endif
                    end
                end
                ST_W_SETUP: begin
                    state <= ST_W_PULSE;
                    cnt   <= PULSE_LOAD;
                    WR    <= 1'b0;
                end
                ST_W_PULSE: begin
                    if (cnt == 8'd0) begin
                        state <= ST_W_HOLD;
                        WR    <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_W_HOLD: begin
                    state   <= ST_RECOVER;
                    cnt     <= GAP_LOAD;
                    ext     <= 1'b0;
                    CS      <= 1'b1;
                    data_oe <= 1'b0;
                end
`ifdef PIC_HOST_READBACK_EN
                ST_R_PULSE: begin
                    if (cnt == 8'd0) begin
                        rd_data  <= DATABUS;
                        rd_valid <= 1'b1;
                        RD       <= 1'b1;
                        CS       <= 1'b1;
                        state    <= ST_RECOVER;
                        cnt      <= GAP_LOAD;
                        ext      <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
`endif
                ST_ACK1: begin
                    if (cnt == 8'd0) begin
                        state <= ST_ACK_GAP;
                        cnt   <= GAP_LOAD;
                        INTA  <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_ACK_GAP: begin
                    if (cnt == 8'd0) begin
                        state <= ST_ACK2;
                        cnt   <= PULSE_LOAD;
                        INTA  <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_ACK2: begin
                    if (cnt == 8'd0) begin
                        vector       <= DATABUS;
                        vector_valid <= 1'b1;
                        INTA         <= 1'b1;
                        state        <= ST_RECOVER;
                        cnt          <= GAP_LOAD;
                        ext          <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_RECOVER: begin
                    // After an acknowledge, two extra cycles let a dropped INT clear the synchroniser;
                    // the extension is a second counter pass so GAP_CYCLES=255 still fits in 8 bits.
                    if (cnt == 8'd0) begin
                        if (ext) begin
                            ext <= 1'b0;
                            cnt <= 8'd1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
